// File: rtl/count_seq_monitor.sv
// Observer that checks a counter steps by exactly +1/-1 each clock.
// Flags mismatches and wraps, tallies errors, latches a sticky fault.
module count_seq_monitor #(
  parameter int WIDTH        = 4,
  parameter int ERR_CNT_W    = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ud,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clr,
  output logic                 err,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 wrap_up,
  output logic                 wrap_dn,
  output logic                 synced
);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LP_TOP = '1;
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] LP_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] LP_INC = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] LP_THR =
    ERR_CNT_W'(FAULT_THRESH);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]     r_prev_count;
  logic                 r_prev_ud;
  logic                 r_err;
  logic                 r_fault;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_wrap_up;
  logic                 r_wrap_dn;
  logic                 r_synced;

  logic [WIDTH-1:0]     w_exp;
  logic                 w_cmp;
  logic                 w_mis;
  logic [ERR_CNT_W-1:0] w_cnt_inc;
  logic                 w_hit_thr;

  logic                 w_err_nxt;
  logic                 w_fault_nxt;
  logic [ERR_CNT_W-1:0] w_cnt_nxt;
  logic                 w_wu_nxt;
  logic                 w_wd_nxt;
  logic                 w_sync_nxt;

  // Expectation follows the last observed sample, so a glitch re-syncs.
  always_comb begin
    w_exp = r_prev_ud ? (r_prev_count + LP_ONE)
                      : (r_prev_count - LP_ONE);
    w_cmp = (r_state == S_TRACK) || (r_state == S_FAULT);
    w_mis = w_cmp && (count != w_exp);
    w_cnt_inc = (r_err_cnt == LP_MAX) ? r_err_cnt
                                      : (r_err_cnt + LP_INC);
    w_hit_thr = (w_cnt_inc >= LP_THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_SYNC;
    end else begin
      unique case (r_state)
        S_SYNC:  w_state_nxt = S_TRACK;
        S_TRACK: begin
          if (w_mis && w_hit_thr) begin
            w_state_nxt = S_FAULT;
          end
        end
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_SYNC;
      endcase
    end
  end

  always_comb begin
    w_err_nxt   = 1'b0;
    w_fault_nxt = 1'b0;
    w_cnt_nxt   = '0;
    w_wu_nxt    = 1'b0;
    w_wd_nxt    = 1'b0;
    w_sync_nxt  = 1'b0;
    if (!clr) begin
      w_sync_nxt  = 1'b1;
      w_err_nxt   = w_mis;
      w_cnt_nxt   = w_mis ? w_cnt_inc : r_err_cnt;
      w_fault_nxt = (r_state == S_FAULT) ||
                    ((r_state == S_TRACK) && w_mis && w_hit_thr);
      w_wu_nxt    = w_cmp && !w_mis && r_prev_ud &&
                    (r_prev_count == LP_TOP) && (count == '0);
      w_wd_nxt    = w_cmp && !w_mis && !r_prev_ud &&
                    (r_prev_count == '0) && (count == LP_TOP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_count <= '0;
      r_prev_ud    <= 1'b0;
      r_err        <= 1'b0;
      r_fault      <= 1'b0;
      r_err_cnt    <= '0;
      r_wrap_up    <= 1'b0;
      r_wrap_dn    <= 1'b0;
      r_synced     <= 1'b0;
    end else begin
      r_prev_count <= count;
      r_prev_ud    <= ud;
      r_err        <= w_err_nxt;
      r_fault      <= w_fault_nxt;
      r_err_cnt    <= w_cnt_nxt;
      r_wrap_up    <= w_wu_nxt;
      r_wrap_dn    <= w_wd_nxt;
      r_synced     <= w_sync_nxt;
    end
  end

  assign err     = r_err;
  assign fault   = r_fault;
  assign err_cnt = r_err_cnt;
  assign wrap_up = r_wrap_up;
  assign wrap_dn = r_wrap_dn;
  assign synced  = r_synced;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: directed vector table plus random
// stimulus against a sequence-level reference model (two configs).
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       ud;
  logic [3:0] count;
  logic       clr;

  logic       err1, fault1, wu1, wd1, sy1;
  logic [7:0] cnt1;
  logic       err2, fault2, wu2, wd2, sy2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(4), .ERR_CNT_W(8), .FAULT_THRESH(3)) dut (
    .clk(clk), .rst(rst), .ud(ud), .count(count), .clr(clr),
    .err(err1), .fault(fault1), .err_cnt(cnt1),
    .wrap_up(wu1), .wrap_dn(wd1), .synced(sy1)
  );

  count_seq_monitor #(.WIDTH(4), .ERR_CNT_W(2), .FAULT_THRESH(3)) dut2 (
    .clk(clk), .rst(rst), .ud(ud), .count(count), .clr(clr),
    .err(err2), .fault(fault2), .err_cnt(cnt2),
    .wrap_up(wu2), .wrap_dn(wd2), .synced(sy2)
  );

  // Reference model: index 0 = 8-bit tally, index 1 = 2-bit tally
  bit m_ref  [2];
  int m_prev [2];
  bit m_pud  [2];
  int m_errs [2];
  bit e_err  [2];
  bit e_wu   [2];
  bit e_wd   [2];
  bit e_sync [2];
  int m_max  [2] = '{255, 3};
  int m_thr  [2] = '{3, 3};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c,
                            input bit u, input int cv);
    for (int k = 0; k < 2; k++) begin
      e_err[k] = 0; e_wu[k] = 0; e_wd[k] = 0;
      if (r) begin
        m_ref[k] = 0; m_prev[k] = 0; m_pud[k] = 0;
        m_errs[k] = 0; e_sync[k] = 0;
      end else if (c) begin
        m_errs[k] = 0; e_sync[k] = 0; m_ref[k] = 0;
        m_prev[k] = cv; m_pud[k] = u;
      end else begin
        if (m_ref[k]) begin
          int nxt;
          nxt = (m_prev[k] + (m_pud[k] ? 1 : 15)) % 16;
          if (cv != nxt) begin
            m_errs[k]++;
            e_err[k] = 1;
          end else begin
            e_wu[k] = m_pud[k] && m_prev[k] == 15 && cv == 0;
            e_wd[k] = !m_pud[k] && m_prev[k] == 0 && cv == 15;
          end
        end
        m_ref[k] = 1; e_sync[k] = 1;
        m_prev[k] = cv; m_pud[k] = u;
      end
    end
  endtask

  function automatic int sat(input int k);
    return (m_errs[k] > m_max[k]) ? m_max[k] : m_errs[k];
  endfunction

  task automatic step(input bit r, input bit c,
                      input bit u, input int cv);
    rst = r; clr = c; ud = u; count = 4'(cv);
    @(posedge clk);
    model_step(r, c, u, cv);
    #1;
    chk("m1.err",     int'(err1),   int'(e_err[0]));
    chk("m1.wrap_up", int'(wu1),    int'(e_wu[0]));
    chk("m1.wrap_dn", int'(wd1),    int'(e_wd[0]));
    chk("m1.synced",  int'(sy1),    int'(e_sync[0]));
    chk("m1.err_cnt", int'(cnt1),   sat(0));
    chk("m1.fault",   int'(fault1), int'(m_errs[0] >= m_thr[0]));
    chk("m2.err",     int'(err2),   int'(e_err[1]));
    chk("m2.wrap_up", int'(wu2),    int'(e_wu[1]));
    chk("m2.wrap_dn", int'(wd2),    int'(e_wd[1]));
    chk("m2.synced",  int'(sy2),    int'(e_sync[1]));
    chk("m2.err_cnt", int'(cnt2),   sat(1));
    chk("m2.fault",   int'(fault2), int'(m_errs[1] >= m_thr[1]));
  endtask

  typedef struct {
    bit r, c, u;
    int cv;
    bit err, wu, wd, sy;
    int c1;
    bit f1;
    int c2;
    bit f2;
  } vec_t;

  vec_t tbl[$];

  task automatic t(input bit r, input bit c, input bit u, input int cv,
                   input bit er, input bit wu, input bit wd, input bit sy,
                   input int c1, input bit f1, input int c2, input bit f2);
    vec_t v;
    v.r = r; v.c = c; v.u = u; v.cv = cv;
    v.err = er; v.wu = wu; v.wd = wd; v.sy = sy;
    v.c1 = c1; v.f1 = f1; v.c2 = c2; v.f2 = f2;
    tbl.push_back(v);
  endtask

  task automatic ok(input bit u, input int cv, input int c1,
                    input bit f1, input int c2, input bit f2);
    t(0, 0, u, cv, 0, 0, 0, 1, c1, f1, c2, f2);
  endtask

  task automatic bad(input bit u, input int cv, input int c1,
                     input bit f1, input int c2, input bit f2);
    t(0, 0, u, cv, 1, 0, 0, 1, c1, f1, c2, f2);
  endtask

  initial begin
    int cur, cur_ud, nv, rr;
    bit r, c, u;

    // reset then full up-count with wrap
    for (int i = 0; i < 3; i++) t(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) ok(1, i, 0, 0, 0, 0);
    t(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    ok(1, 1, 0, 0, 0, 0);
    // down-count with wrap
    ok(0, 2, 0, 0, 0, 0);
    ok(0, 1, 0, 0, 0, 0);
    ok(0, 0, 0, 0, 0, 0);
    t(0, 0, 0, 15, 0, 0, 1, 1, 0, 0, 0, 0);
    ok(0, 14, 0, 0, 0, 0);
    for (int i = 13; i >= 6; i--) ok(0, i, 0, 0, 0, 0);
    // direction reversal
    ok(1, 5, 0, 0, 0, 0);
    ok(1, 6, 0, 0, 0, 0);
    ok(0, 7, 0, 0, 0, 0);
    ok(0, 6, 0, 0, 0, 0);
    ok(0, 5, 0, 0, 0, 0);
    // glitch and re-sync
    ok(0, 4, 0, 0, 0, 0);
    ok(1, 3, 0, 0, 0, 0);
    ok(1, 4, 0, 0, 0, 0);
    bad(1, 9, 1, 0, 1, 0);
    ok(1, 10, 1, 0, 1, 0);
    ok(1, 11, 1, 0, 1, 0);
    // fault and saturation
    t(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ok(1, 0, 0, 0, 0, 0);
    ok(1, 1, 0, 0, 0, 0);
    ok(1, 2, 0, 0, 0, 0);
    bad(1, 5, 1, 0, 1, 0);
    ok(1, 6, 1, 0, 1, 0);
    bad(1, 9, 2, 0, 2, 0);
    ok(1, 10, 2, 0, 2, 0);
    bad(1, 13, 3, 1, 3, 1);
    ok(1, 14, 3, 1, 3, 1);
    bad(1, 1, 4, 1, 3, 1);
    ok(1, 2, 4, 1, 3, 1);
    bad(1, 7, 5, 1, 3, 1);
    // clear out of fault, then a held count
    t(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    ok(1, 8, 0, 0, 0, 0);
    ok(1, 9, 0, 0, 0, 0);
    bad(1, 9, 1, 0, 1, 0);
    ok(1, 10, 1, 0, 1, 0);
    // rst and clr together mid-run
    t(1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    ok(1, 0, 0, 0, 0, 0);
    ok(1, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].u, tbl[i].cv);
      chk("v.err",     int'(err1),   int'(tbl[i].err));
      chk("v.wrap_up", int'(wu1),    int'(tbl[i].wu));
      chk("v.wrap_dn", int'(wd1),    int'(tbl[i].wd));
      chk("v.synced",  int'(sy1),    int'(tbl[i].sy));
      chk("v.cnt1",    int'(cnt1),   tbl[i].c1);
      chk("v.fault1",  int'(fault1), int'(tbl[i].f1));
      chk("v.cnt2",    int'(cnt2),   tbl[i].c2);
      chk("v.fault2",  int'(fault2), int'(tbl[i].f2));
    end

    // random stimulus: mostly legal steps, some glitches, clr, rst
    cur = 1; cur_ud = 1;
    for (int n = 0; n < 3000; n++) begin
      rr = $urandom_range(0, 99);
      r  = (rr < 2);
      c  = (rr >= 2 && rr < 5) || (rr == 0);
      u  = 1'($urandom_range(0, 1));
      if (r) nv = 0;
      else if (rr >= 5 && rr < 15) nv = $urandom_range(0, 15);
      else nv = (cur + (cur_ud != 0 ? 1 : 15)) % 16;
      step(r, c, u, nv);
      cur = nv; cur_ud = int'(u);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
